// File: rtl/mau_pkg.sv
// Shared encodings and helpers for the memory access unit.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    // True when the access does not sit on its natural boundary; reserved size always trips.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane steering: load extract/extend and sub-word store merge.
// Half accesses pick their lane from addr_lo[1] only, so a misaligned half
// (when alignment checking is off) lands on the aligned half of the word.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [3:0]  lane_hit;

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    always_comb begin
        byte_sel  = word[8*addr_lo +: 8];
        half_sel  = word[16*addr_lo[1] +: 16];
        load_data = word;
        case (size)
            SZ_BYTE: load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{is_signed & half_sel[15]}}, half_sel};
            default: load_data = word;
        endcase
    end

    // Each byte lane takes store data when the access covers it, else keeps the old word.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_hit[gi] = (size == SZ_WORD)
                            | ((size == SZ_BYTE) & (addr_lo == 2'(gi)))
                            | ((size == SZ_HALF) & (addr_lo[1] == 1'(gi / 2)));

        assign store_word[8*gi +: 8] = !lane_hit[gi]     ? word[8*gi +: 8]
                                     : (size == SZ_BYTE) ? wdata[7:0]
                                     : (size == SZ_HALF) ? wdata[8*(gi % 2) +: 8]
                                     :                     wdata[8*gi +: 8];
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the MEM stage and a word-wide syncram without
// byte enables. Sub-word stores are done as read-modify-write.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter bit MISALIGN_CHECK = 1'b1,
    parameter bit ZERO_ON_ERR    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_cs,
    output logic              mem_oe,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    state_t            state_reg, state_next;
    logic              we_reg;
    logic [1:0]        size_reg;
    logic              signed_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic              err_reg;
    logic [31:0]       data_q;

    logic              accept;
    logic              req_err;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign req_ready = (state_reg == IDLE) & rst_n;
    assign accept    = req_valid & req_ready;

    // Reserved size is an error regardless of the alignment check setting.
    assign req_err = (req_size == SZ_RSVD)
                   | (MISALIGN_CHECK & is_misaligned(req_size, req_addr[1:0]));

    mau_lane_align u_align (
        .size       (size_reg),
        .is_signed  (signed_reg),
        .addr_lo    (addr_reg[1:0]),
        .word       (data_q),
        .wdata      (wdata_reg),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request capture at accept and read-data capture in WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_reg     <= 1'b0;
            size_reg   <= SZ_BYTE;
            signed_reg <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            err_reg    <= 1'b0;
            data_q     <= '0;
        end else begin
            if (accept) begin
                we_reg     <= req_we;
                size_reg   <= req_size;
                signed_reg <= req_signed;
                addr_reg   <= req_addr;
                wdata_reg  <= req_wdata;
                err_reg    <= req_err;
            end
            if (state_reg == WAIT) begin
                data_q <= mem_dout;
            end
        end
    end

    // Next-state decode; word stores skip the read, errors skip memory entirely.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_err)                             state_next = RESP;
                    else if (!req_we || req_size != SZ_WORD) state_next = RD;
                    else                                     state_next = WR;
                end
            end
            RD:      state_next = WAIT;
            WAIT:    state_next = we_reg ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs; everything is held at zero while rst_n is low.
    always_comb begin
        mem_cs     = 1'b0;
        mem_oe     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        if (rst_n) begin
            case (state_reg)
                RD: begin
                    mem_cs   = 1'b1;
                    mem_oe   = 1'b1;
                    mem_addr = {addr_reg[ADDR_W-1:2], 2'b00};
                end
                WR: begin
                    mem_cs   = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = {addr_reg[ADDR_W-1:2], 2'b00};
                    mem_din  = store_word;
                end
                RESP: begin
                    resp_valid = 1'b1;
                    resp_err   = err_reg;
                    if (err_reg)      resp_rdata = ZERO_ON_ERR ? 32'd0 : load_data;
                    else if (!we_reg) resp_rdata = load_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a behavioural syncram.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_cs;
    logic        mem_oe;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int checks   = 0;
    int failures = 0;

    // Activity counters maintained by the monitor only.
    int          cs_cnt   = 0;
    int          we_cnt   = 0;
    int          resp_cnt = 0;
    logic [31:0] last_din = 32'd0;

    logic [31:0] ram [0:255];

    mem_access_unit #(
        .ADDR_W         (32),
        .MISALIGN_CHECK (1'b1),
        .ZERO_ON_ERR    (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_cs     (mem_cs),
        .mem_oe     (mem_oe),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always #5 clk = ~clk;

    // Syncram model plus activity monitor.
    always @(posedge clk) begin
        if (mem_cs && mem_oe && !mem_we) mem_dout <= ram[mem_addr[9:2]];
        if (mem_cs && mem_we) begin
            ram[mem_addr[9:2]] <= mem_din;
            last_din           <= mem_din;
            we_cnt             <= we_cnt + 1;
        end
        if (mem_cs)     cs_cnt   <= cs_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request from a negedge and return at the negedge after the response.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
        int          lat;
        logic [31:0] rdata;
        logic        err;
        lat   = 0;
        rdata = 32'd0;
        err   = 1'b0;
        check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the unit must use its registered copy.
        req_valid  = 1'b0;
        req_we     = ~we;
        req_size   = ~size;
        req_signed = ~sgn;
        req_addr   = ~addr;
        req_wdata  = ~wdata;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat   = k;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
        $display("txn %s we=%0b size=%0d addr=0x%08h lat=%0d rdata=0x%08h err=%0b",
                 tag, we, size, addr, lat, rdata, err);
        check({tag, ".lat"},   lat,   exp_lat);
        check({tag, ".rdata"}, rdata, exp_rdata);
        check({tag, ".err"},   {31'd0, err}, {31'd0, exp_err});
        @(negedge clk);
        check({tag, ".pulse"}, {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        int cs0;
        int we0;
        int rc0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.ready",  {31'd0, req_ready},  32'd0);
        check("rst.valid",  {31'd0, resp_valid}, 32'd0);
        check("rst.cs",     {31'd0, mem_cs},     32'd0);
        check("rst.rdata",  resp_rdata,          32'd0);
        rst_n = 1'b1;
        #1;
        check("rst.ready_hi", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        // Preload by word store, then loads from several lanes.
        do_req("sw_pre", 1'b1, 2'b10, 1'b0, 32'h1000_0024, 32'h8070_F0AA, 2, 32'd0, 1'b0);
        check("sw_pre.din", last_din, 32'h8070_F0AA);
        do_req("lb",   1'b0, 2'b00, 1'b1, 32'h1000_0024, 32'd0, 3, 32'hFFFF_FFAA, 1'b0);
        do_req("lbu",  1'b0, 2'b00, 1'b0, 32'h1000_0025, 32'd0, 3, 32'h0000_00F0, 1'b0);
        do_req("lb3",  1'b0, 2'b00, 1'b1, 32'h1000_0027, 32'd0, 3, 32'hFFFF_FF80, 1'b0);
        do_req("lbu2", 1'b0, 2'b00, 1'b0, 32'h1000_0026, 32'd0, 3, 32'h0000_0070, 1'b0);
        do_req("lh",   1'b0, 2'b01, 1'b1, 32'h1000_0026, 32'd0, 3, 32'hFFFF_8070, 1'b0);
        do_req("lhu",  1'b0, 2'b01, 1'b0, 32'h1000_0024, 32'd0, 3, 32'h0000_F0AA, 1'b0);
        do_req("lw",   1'b0, 2'b10, 1'b0, 32'h1000_0024, 32'd0, 3, 32'h8070_F0AA, 1'b0);

        // Word store: exactly one write cycle.
        we0 = we_cnt;
        do_req("sw",   1'b1, 2'b10, 1'b0, 32'h0040_003C, 32'h0000_000E, 2, 32'd0, 1'b0);
        check("sw.wecnt", we_cnt - we0, 1);
        check("sw.din",   last_din, 32'h0000_000E);
        do_req("lw2",  1'b0, 2'b10, 1'b0, 32'h0040_003C, 32'd0, 3, 32'h0000_000E, 1'b0);

        // Sub-word stores via read-modify-write.
        do_req("sw3",  1'b1, 2'b10, 1'b0, 32'h1000_0040, 32'h1122_3344, 2, 32'd0, 1'b0);
        do_req("sb",   1'b1, 2'b00, 1'b0, 32'h1000_0042, 32'h0000_0077, 4, 32'd0, 1'b0);
        check("sb.din", last_din, 32'h1177_3344);
        do_req("sh",   1'b1, 2'b01, 1'b0, 32'h1000_0040, 32'h0000_BEEF, 4, 32'd0, 1'b0);
        check("sh.din", last_din, 32'h1177_BEEF);
        do_req("lw3",  1'b0, 2'b10, 1'b0, 32'h1000_0040, 32'd0, 3, 32'h1177_BEEF, 1'b0);

        // Errors: no memory cycle at all.
        cs0 = cs_cnt;
        do_req("lw_mis", 1'b0, 2'b10, 1'b0, 32'h1000_0026, 32'd0, 1, 32'd0, 1'b1);
        do_req("lh_mis", 1'b0, 2'b01, 1'b1, 32'h1000_0021, 32'd0, 1, 32'd0, 1'b1);
        do_req("sz_rsv", 1'b1, 2'b11, 1'b0, 32'h1000_0040, 32'h0000_0055, 1, 32'd0, 1'b1);
        check("err.cs", cs_cnt - cs0, 0);

        // Reset during WAIT of a sub-word store aborts it cleanly.
        we0 = we_cnt;
        rc0 = resp_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h1000_0041;
        req_wdata  = 32'h0000_00CC;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.cs_low", {31'd0, mem_cs}, 32'd0);
        @(negedge clk);
        check("abort.ready_low", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("abort.ready", {31'd0, req_ready}, 32'd1);
        repeat (6) @(negedge clk);
        check("abort.we",   we_cnt - we0,   0);
        check("abort.resp", resp_cnt - rc0, 0);
        do_req("lw4", 1'b0, 2'b10, 1'b0, 32'h1000_0040, 32'd0, 3, 32'h1177_BEEF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
